// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read master (AR/R) between two requesters, tags AR with the winner index.
// Build option: define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 first) instead of round-robin.
module axi_read_arbiter #(
   parameter int ADDR_WIDTH      = 56,
   parameter int DATA_WIDTH      = 64,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [1:0]              req_ar_valid,
   output logic [1:0]              req_ar_ready,
   input  logic [2*ADDR_WIDTH-1:0] req_ar_addr,
   input  logic [15:0]             req_ar_len,
   input  logic [5:0]              req_ar_size,
   output logic [1:0]              req_r_valid,
   input  logic [1:0]              req_r_ready,
   output logic [DATA_WIDTH-1:0]   req_r_data,
   output logic [1:0]              req_r_resp,
   output logic                    req_r_last,
   output logic                    m_ar_valid,
   input  logic                    m_ar_ready,
   output logic [ADDR_WIDTH-1:0]   m_ar_addr,
   output logic                    m_ar_id,
   output logic [7:0]              m_ar_len,
   output logic [2:0]              m_ar_size,
   input  logic                    m_r_valid,
   output logic                    m_r_ready,
   input  logic [DATA_WIDTH-1:0]   m_r_data,
   input  logic                    m_r_id,
   input  logic [1:0]              m_r_resp,
   input  logic                    m_r_last,
   output logic                    err
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t             state_q, state_d;
   logic               hold_id_q, hold_id_d;
   logic [1:0][CW-1:0] cnt_q, cnt_d;
   logic               err_q, err_d;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
   logic               ptr_q, ptr_d;
`endif

   logic [1:0] elig;
   logic       arb_id, win_id, grant, ar_hs, orphan, r_hs;

   always_comb begin
      // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
      for (int i = 0; i < 2; i++) elig[i] = req_ar_valid[i] && (cnt_q[i] < MAX_CNT);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      arb_id = ~elig[0];
`else
      arb_id = elig[ptr_q] ? ptr_q : ~ptr_q;
`endif
      // While held, the locked requester owns the port regardless of eligibility changes.
      win_id = (state_q == HOLD) ? hold_id_q : arb_id;
      grant  = (state_q == HOLD) || (rstn && (elig != 2'b00));
      ar_hs  = grant && m_ar_ready;

      orphan = m_r_valid && (cnt_q[m_r_id] == '0);
      r_hs   = m_r_valid && m_r_ready;

      state_d   = (grant && !m_ar_ready) ? HOLD : IDLE;
      hold_id_d = (grant && !m_ar_ready) ? win_id : hold_id_q;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
      ptr_d     = ar_hs ? ~ptr_q : ptr_q;
`endif
      err_d     = err_q || orphan;

      cnt_d = cnt_q;
      for (int i = 0; i < 2; i++) begin
         logic inc, dec;
         inc = ar_hs && (win_id == 1'(i));
         dec = r_hs && m_r_last && !orphan && (m_r_id == 1'(i));
         if (inc && !dec)      cnt_d[i] = cnt_q[i] + CW'(1);
         else if (dec && !inc) cnt_d[i] = cnt_q[i] - CW'(1);
      end
   end

   assign m_ar_valid   = grant;
   assign m_ar_id      = win_id;
   assign m_ar_addr    = win_id ? req_ar_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_ar_addr[ADDR_WIDTH-1:0];
   assign m_ar_len     = win_id ? req_ar_len[15:8] : req_ar_len[7:0];
   assign m_ar_size    = win_id ? req_ar_size[5:3] : req_ar_size[2:0];
   assign req_ar_ready = ar_hs ? (win_id ? 2'b10 : 2'b01) : 2'b00;

   // Orphan beats are drained by the arbiter itself and never shown to a requester.
   assign req_r_valid  = (m_r_valid && !orphan) ? (m_r_id ? 2'b10 : 2'b01) : 2'b00;
   assign m_r_ready    = orphan || req_r_ready[m_r_id];
   assign req_r_data   = m_r_data;
   assign req_r_resp   = m_r_resp;
   assign req_r_last   = m_r_last;
   assign err          = err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         hold_id_q <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
         ptr_q     <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
         state_q   <= state_d;
         hold_id_q <= hold_id_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: a transaction-level model predicts grants, routing and err;
// a negedge monitor pops and compares. Honors AXI_RD_ARB_FIXED_PRIO_EN.
`timescale 1ns/1ps
module tb_axi_read_arbiter;

   localparam int AW = 56, DW = 64, MAXO = 4;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic            clk = 1'b0, rstn = 1'b0;
   logic [1:0]      req_ar_valid = '0, req_ar_ready, req_r_valid, req_r_ready = '0, req_r_resp, m_r_resp = '0;
   logic [2*AW-1:0] req_ar_addr = '0;
   logic [15:0]     req_ar_len = '0;
   logic [5:0]      req_ar_size = '0;
   logic [DW-1:0]   req_r_data, m_r_data = '0;
   logic            req_r_last, m_ar_valid, m_ar_ready = 1'b0, m_ar_id, m_r_valid = 1'b0, m_r_ready;
   logic            m_r_id = 1'b0, m_r_last = 1'b0, err;
   logic [AW-1:0]   m_ar_addr;
   logic [7:0]      m_ar_len;
   logic [2:0]      m_ar_size;

   always #5 clk = ~clk;

   axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rstn(rstn),
      .req_ar_valid(req_ar_valid), .req_ar_ready(req_ar_ready), .req_ar_addr(req_ar_addr),
      .req_ar_len(req_ar_len), .req_ar_size(req_ar_size),
      .req_r_valid(req_r_valid), .req_r_ready(req_r_ready), .req_r_data(req_r_data),
      .req_r_resp(req_r_resp), .req_r_last(req_r_last),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
      .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_id(m_r_id),
      .m_r_resp(m_r_resp), .m_r_last(m_r_last), .err(err)
   );

   typedef struct {logic id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size;} ar_t;
   typedef struct {logic [1:0] rv; logic mrr; logic [DW-1:0] data; logic [1:0] resp; logic last;} r_t;
   typedef struct {logic mav; logic id; logic [1:0] arr; logic err;} st_t;
   typedef struct {logic id; int left;} txn_t;

   ar_t  ar_q[$];
   r_t   r_q[$];
   st_t  st_q[$];
   txn_t pend_q[$];
   int   checks = 0, errors = 0;
   bit   run = 1'b0;

   // Stimulus state: requesters, memory slave, reset.
   logic                rst_v = 1'b0, mar_v = 1'b0;
   logic [1:0]          rq_v = '0, rr_v = '0;
   logic [1:0][AW-1:0]  rq_addr = '0;
   logic [1:0][7:0]     rq_len = '0;
   logic [1:0][2:0]     rq_size = '0;
   logic                bt_v = 1'b0, bt_id = 1'b0, bt_last = 1'b0, bt_fromq = 1'b0;
   logic [DW-1:0]       bt_data = '0;
   logic [1:0]          bt_resp = '0;

   // Reference model state.
   int   m_cnt[2] = '{0, 0};
   logic m_ptr = 1'b0, m_lock = 1'b0, m_lid = 1'b0, m_err = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_req(int i, int len);
      rq_v[i]    = 1'b1;
      rq_addr[i] = AW'({$urandom(), $urandom()});
      rq_len[i]  = 8'(len);
      rq_size[i] = 3'($urandom_range(7));
   endtask

   task automatic queue_beat();
      bt_v     = 1'b1;
      bt_fromq = 1'b1;
      bt_id    = pend_q[0].id;
      bt_last  = (pend_q[0].left == 1);
      bt_data  = {$urandom(), $urandom()};
      bt_resp  = 2'($urandom());
   endtask

   task automatic rand_inputs(int p_req, int p_ar, int p_beat, int p_rr, int p_orph);
      for (int i = 0; i < 2; i++) begin
         if (!rq_v[i] && $urandom_range(99) < p_req) set_req(i, $urandom_range(3));
         rr_v[i] = ($urandom_range(99) < p_rr);
      end
      mar_v = ($urandom_range(99) < p_ar);
      if (!bt_v) begin
         if (pend_q.size() > 0 && $urandom_range(99) < p_beat) queue_beat();
         else if ($urandom_range(999) < p_orph) begin
            bt_id = 1'($urandom());
            if (m_cnt[bt_id] == 0) begin
               bt_v     = 1'b1;
               bt_fromq = 1'b0;
               bt_last  = 1'($urandom());
               bt_data  = {$urandom(), $urandom()};
               bt_resp  = 2'($urandom());
            end
         end
      end
   endtask

   // One clock: drive inputs, predict this cycle's outputs from the rules, advance the model.
   task automatic step();
      st_t s; ar_t a; r_t r;
      logic [1:0] elig;
      logic vld, win, hs, orph, mrr, rhs, pref;
      @(posedge clk); #1;
      rstn         = rst_v;
      req_ar_valid = rq_v;
      req_ar_addr  = {rq_addr[1], rq_addr[0]};
      req_ar_len   = {rq_len[1], rq_len[0]};
      req_ar_size  = {rq_size[1], rq_size[0]};
      m_ar_ready   = mar_v;
      req_r_ready  = rr_v;
      m_r_valid    = bt_v;
      m_r_id       = bt_id;
      m_r_data     = bt_data;
      m_r_resp     = bt_resp;
      m_r_last     = bt_last;
      if (!rst_v) begin
         m_cnt = '{0, 0}; m_ptr = 1'b0; m_lock = 1'b0; m_err = 1'b0;
         pend_q.delete();
      end
      for (int i = 0; i < 2; i++) elig[i] = rq_v[i] && (m_cnt[i] < MAXO);
      pref = FIXED ? 1'b0 : m_ptr;
      win  = m_lock ? m_lid : (elig[pref] ? pref : ~pref);
      vld  = rst_v && (m_lock || elig != 2'b00);
      hs   = vld && mar_v;
      s.mav = vld; s.id = win; s.arr = hs ? (win ? 2'b10 : 2'b01) : 2'b00; s.err = m_err;
      st_q.push_back(s);
      if (hs) begin
         a.id = win; a.addr = rq_addr[win]; a.len = rq_len[win]; a.size = rq_size[win];
         ar_q.push_back(a);
      end
      orph = bt_v && (m_cnt[bt_id] == 0);
      mrr  = orph || rr_v[bt_id];
      rhs  = bt_v && mrr;
      if (bt_v) begin
         r.rv = orph ? 2'b00 : (bt_id ? 2'b10 : 2'b01);
         r.mrr = mrr; r.data = bt_data; r.resp = bt_resp; r.last = bt_last;
         r_q.push_back(r);
      end
      if (rst_v) begin
         if (orph) m_err = 1'b1;
         m_lock = vld && !mar_v;
         m_lid  = win;
         if (hs) begin
            m_ptr = ~m_ptr;
            m_cnt[win]++;
            pend_q.push_back('{win, int'(rq_len[win]) + 1});
         end
         if (rhs && bt_last && !orph) m_cnt[bt_id]--;
         if (rhs && bt_fromq) begin
            pend_q[0].left = pend_q[0].left - 1;
            if (pend_q[0].left == 0) void'(pend_q.pop_front());
         end
      end
      if (hs) rq_v[win] = 1'b0;
      if (rhs) bt_v = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && (pend_q.size() > 0 || bt_v || rq_v != 2'b00); n++) begin
         rand_inputs(0, 100, 100, 100, 0);
         step();
      end
      check("drain_done", {62'd0, bt_v, (pend_q.size() > 0 || rq_v != 2'b00)}, 64'd0);
   endtask

   // Monitor: compares whatever the DUT presents against the queued predictions.
   initial begin : monitor
      st_t s; ar_t a; r_t r;
      forever begin
         @(negedge clk);
         if (run) begin
            if (st_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL status_queue: got empty expected one entry");
            end else begin
               s = st_q.pop_front();
               check("m_ar_valid", m_ar_valid, s.mav);
               check("req_ar_ready", req_ar_ready, s.arr);
               check("err", err, s.err);
               if (s.mav) check("m_ar_id", m_ar_id, s.id);
            end
            if (m_ar_valid && m_ar_ready) begin
               if (ar_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL ar_unexpected: got handshake id %0d expected none", m_ar_id);
               end else begin
                  a = ar_q.pop_front();
                  check("ar_id", m_ar_id, a.id);
                  check("ar_addr", m_ar_addr, a.addr);
                  check("ar_len", m_ar_len, a.len);
                  check("ar_size", m_ar_size, a.size);
               end
            end
            if (m_r_valid) begin
               if (r_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL r_queue: got empty expected one entry");
               end else begin
                  r = r_q.pop_front();
                  check("req_r_valid", req_r_valid, r.rv);
                  check("m_r_ready", m_r_ready, r.mrr);
                  check("req_r_data", req_r_data, r.data);
                  check("req_r_resp", req_r_resp, r.resp);
                  check("req_r_last", req_r_last, r.last);
               end
            end
         end
      end
   end

   initial begin
      run = 1'b1;
      // Reset with noisy inputs: no AR may leave, stray beats are drained.
      for (int n = 0; n < 3; n++) begin rand_inputs(60, 50, 0, 50, 600); step(); end
      rst_v = 1'b1;
      bt_v  = 1'b0;

      // Single requester, then its single-beat response, then an orphan on the same id.
      rq_v = 2'b00; rr_v = 2'b00;
      set_req(1, 0); rq_addr[1] = 56'h8000_0000; mar_v = 1'b1; step();
      mar_v = 1'b0; rr_v = 2'b10; queue_beat(); step();
      bt_v = 1'b1; bt_fromq = 1'b0; bt_id = 1'b1; bt_last = 1'b1; rr_v = 2'b00; step();
      step();

      // Contention with both requesters continuously valid.
      mar_v = 1'b1;
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 2; i++) if (!rq_v[i]) set_req(i, 0);
         step();
      end
      drain();

      // Backpressure: req0 held while req1 joins.
      set_req(0, 0); mar_v = 1'b0; step();
      set_req(1, 0); step(); step();
      mar_v = 1'b1; step(); step();
      drain();

      // Outstanding limit on req0, then one last beat frees a slot.
      mar_v = 1'b1; rr_v = 2'b11;
      for (int n = 0; n < 5; n++) begin if (!rq_v[0]) set_req(0, 0); step(); end
      queue_beat(); step(); step();
      drain();

      // Reset while in HOLD with two outstanding on req0.
      mar_v = 1'b1;
      set_req(0, 0); step(); set_req(0, 0); step();
      set_req(0, 0); mar_v = 1'b0; step();
      @(negedge clk); #1;
      rst_v = 1'b0; rstn = 1'b0; #1;
      check("rst_async_m_ar_valid", m_ar_valid, 1'b0);
      check("rst_async_req_ar_ready", req_ar_ready, 2'b00);
      check("rst_async_err", err, 1'b0);
      step(); step();
      rst_v = 1'b1; set_req(1, 0); mar_v = 1'b1; step(); step();
      drain();

      // Randomized traffic: slow responses stress the limit, then fast mixed traffic.
      for (int n = 0; n < 1500; n++) begin
         rand_inputs(70, 60, 15, 70, 4);
         rst_v = ($urandom_range(999) >= 3);
         step();
      end
      rst_v = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         rand_inputs(90, 85, 80, 60, 4);
         step();
      end
      rst_v = 1'b1;
      drain();
      @(negedge clk); #1;
      run = 1'b0;
      check("ar_queue_empty", ar_q.size(), 0);
      check("r_queue_empty", r_q.size(), 0);
      check("status_queue_empty", st_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
